// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector: qualified bit input, selectable
// overlap mode, registered match pulse and a saturating match counter.
module seq_detector_param #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LW-1:0]      fill
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_LEN-1:0] r_pat;
    logic [LW-1:0]      r_len;
    logic               r_ovl;
    logic [MAX_LEN-1:0] r_hist;
    logic [LW-1:0]      r_fill;
    logic               r_match;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [MAX_LEN-1:0] w_mask;
    logic [LW-1:0]      w_fill_next;
    logic [LW-1:0]      w_len_clamped;
    logic               w_hit;

    // A config write owns the cycle, so any bit offered alongside it is dropped.
    assign w_accept    = in_valid && !cfg_we;
    assign w_hist_next = {r_hist[MAX_LEN-2:0], in_bit};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    always_comb begin
        w_fill_next = (r_fill >= r_len) ? r_len : r_fill + LW'(1);
        w_hit       = w_accept && (w_fill_next >= r_len) &&
                      (((w_hist_next ^ r_pat) & w_mask) == '0);
    end

    always_comb begin
        w_len_clamped = cfg_len;
        if (cfg_len == '0) begin
            w_len_clamped = LW'(1);
        end else if (cfg_len > LW'(MAX_LEN)) begin
            w_len_clamped = LW'(MAX_LEN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat   <= MAX_LEN'(13);
            r_len   <= LW'(4);
            r_ovl   <= 1'b0;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
            r_count <= '0;
        end else begin
            if (cfg_we) begin
                r_pat   <= cfg_pattern;
                r_len   <= w_len_clamped;
                r_ovl   <= cfg_overlap;
                r_hist  <= '0;
                r_fill  <= '0;
                r_match <= 1'b0;
            end else if (w_accept) begin
                r_hist  <= w_hist_next;
                // Non-overlapping mode restarts the fill so the next hit needs len fresh bits.
                r_fill  <= (w_hit && !r_ovl) ? '0 : w_fill_next;
                r_match <= w_hit;
            end else begin
                r_match <= 1'b0;
            end

            if (cnt_clr) begin
                r_count <= '0;
            end else if (w_hit && (r_count != CNT_MAX)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign fill        = r_fill;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, hand-written corner
// sequences, and random traffic against a queue-based reference model.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_bit = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               match, match2;
    logic [7:0]         match_count;
    logic [1:0]         match_count2;
    logic [LW-1:0]      fill, fill2;

    int checks = 0;
    int errors = 0;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_bit(in_bit), .cnt_clr(cnt_clr), .match(match),
        .match_count(match_count), .fill(fill)
    );

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_bit(in_bit), .cnt_clr(cnt_clr), .match(match2),
        .match_count(match_count2), .fill(fill2)
    );

    always #5 clk = ~clk;

    // Reference model: list of accepted bits since the last clear.
    logic       m_q[$];
    logic [7:0] m_pat;
    int         m_len;
    logic       m_ovl;
    int         m_match, m_count, m_count2;

    task automatic model_reset();
        m_q.delete();
        m_pat = 8'b1101; m_len = 4; m_ovl = 1'b0;
        m_match = 0; m_count = 0; m_count2 = 0;
    endtask

    function automatic int model_fill();
        return (m_q.size() < m_len) ? m_q.size() : m_len;
    endfunction

    task automatic model_step(input logic we, input logic [7:0] pat, input int len,
                              input logic ovl, input logic v, input logic b, input logic clr);
        int hit = 0;
        if (we) begin
            m_pat = pat;
            m_len = (len == 0) ? 1 : ((len > MAX_LEN) ? MAX_LEN : len);
            m_ovl = ovl;
            m_q.delete();
        end else if (v) begin
            m_q.push_back(b);
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
            if (m_q.size() >= m_len) begin
                hit = 1;
                for (int k = 0; k < m_len; k++)
                    if (m_q[m_q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 0;
                if (hit != 0 && !m_ovl) m_q.delete();
            end
        end
        m_match = hit;
        if (clr) begin
            m_count = 0; m_count2 = 0;
        end else if (hit != 0) begin
            if (m_count < 255) m_count++;
            if (m_count2 < 3) m_count2++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model at the edge, return #1 after the edge.
    task automatic apply(input logic we, input logic [7:0] pat, input int len,
                         input logic ovl, input logic v, input logic b, input logic clr);
        cfg_we = we; cfg_pattern = pat; cfg_len = LW'(len); cfg_overlap = ovl;
        in_valid = v; in_bit = b; cnt_clr = clr;
        @(posedge clk);
        model_step(we, pat, len, ovl, v, b, clr);
        #1;
        cfg_we = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    endtask

    typedef struct {
        logic we; logic [7:0] pat; int len; logic ovl;
        logic v; logic b; logic clr;
        int e_match; int e_count; int e_fill;
    } vec_t;
    vec_t vecs[$];

    task automatic add_bit(input logic b, input int em, input int ec, input int ef);
        vecs.push_back('{1'b0, 8'h00, 0, 1'b0, 1'b1, b, 1'b0, em, ec, ef});
    endtask
    task automatic add_gap(input int ec, input int ef);
        vecs.push_back('{1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, ec, ef});
    endtask
    task automatic add_cfg(input logic [7:0] pat, input int len, input logic ovl);
        vecs.push_back('{1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b1, 0, 0, 0});
    endtask

    initial begin
        model_reset();
        // Defaults, non-overlap: 1,1,0,1,1,0,1
        add_bit(1,0,0,1); add_bit(1,0,0,2); add_bit(0,0,0,3); add_bit(1,1,1,0);
        add_bit(1,0,1,1); add_bit(0,0,1,2); add_bit(1,0,1,3);
        // Overlap on
        add_cfg(8'h0D, 4, 1'b1);
        add_bit(1,0,0,1); add_bit(1,0,0,2); add_bit(0,0,0,3); add_bit(1,1,1,4);
        add_bit(1,0,1,4); add_bit(0,0,1,4); add_bit(1,1,2,4);
        // 101 overlap with two-cycle gaps
        add_cfg(8'h05, 3, 1'b1);
        add_bit(1,0,0,1); add_gap(0,1); add_gap(0,1);
        add_bit(0,0,0,2); add_gap(0,2); add_gap(0,2);
        add_bit(1,1,1,3); add_gap(1,3); add_gap(1,3);
        add_bit(0,0,1,3); add_gap(1,3); add_gap(1,3);
        add_bit(1,1,2,3);
        // 101 non-overlap with gaps
        add_cfg(8'h05, 3, 1'b0);
        add_bit(1,0,0,1); add_gap(0,1); add_gap(0,1);
        add_bit(0,0,0,2); add_gap(0,2); add_gap(0,2);
        add_bit(1,1,1,0); add_gap(1,0); add_gap(1,0);
        add_bit(0,0,1,1); add_gap(1,1); add_gap(1,1);
        add_bit(1,0,1,2);
        // len 0 clamps to 1
        add_cfg(8'h01, 0, 1'b1);
        add_bit(1,1,1,1); add_bit(1,1,2,1); add_bit(0,0,2,1); add_bit(1,1,3,1);
        // len 15 clamps to 8
        add_cfg(8'hA5, 15, 1'b1);
        add_bit(1,0,0,1); add_bit(0,0,0,2); add_bit(1,0,0,3); add_bit(0,0,0,4);
        add_bit(0,0,0,5); add_bit(1,0,0,6); add_bit(0,0,0,7); add_bit(1,1,1,8);
        add_bit(0,0,1,8);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_match", int'(match), 0);
        check("reset_count", int'(match_count), 0);
        check("reset_fill", int'(fill), 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].we, vecs[i].pat, vecs[i].len, vecs[i].ovl,
                  vecs[i].v, vecs[i].b, vecs[i].clr);
            check($sformatf("vec%0d_match", i), int'(match), vecs[i].e_match);
            check($sformatf("vec%0d_count", i), int'(match_count), vecs[i].e_count);
            check($sformatf("vec%0d_fill", i), int'(fill), vecs[i].e_fill);
        end

        // Saturation of the 2-bit counter, then clear colliding with a hit
        apply(1'b1, 8'h01, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
            check("sat_match", int'(match2), 1);
            check("sat_count", int'(match_count2), (i < 3) ? i + 1 : 3);
        end
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_hit_match", int'(match), 1);
        check("clr_hit_count", int'(match_count), 0);
        check("clr_hit_count2", int'(match_count2), 0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("after_clr_count", int'(match_count), 1);

        // Asynchronous reset mid-pattern
        apply(1'b1, 8'h0D, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_fill", int'(fill), 0);
        check("async_rst_count", int'(match_count), 0);
        @(posedge clk);
        #1;
        check("held_rst_match", int'(match), 0);
        rst = 1'b0;
        model_reset();
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("post_rst_bit1_match", int'(match), 0);
        check("post_rst_bit1_fill", int'(fill), 1);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_rst_partial_match", int'(match), 0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("post_rst_hit_match", int'(match), 1);
        check("post_rst_hit_count", int'(match_count), 1);

        // Config write with in_valid high drops the bit
        apply(1'b1, 8'h0D, 4, 1'b0, 1'b1, 1'b1, 1'b0);
        check("cfgwe_fill", int'(fill), 0);
        check("cfgwe_match", int'(match), 0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("cfgwe_drop_match", int'(match), 0);
        check("cfgwe_drop_fill", int'(fill), 3);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("cfgwe_pre_match", int'(match), 0);
        apply(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("cfgwe_hit_match", int'(match), 1);

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic we, v, b, clr, ovl;
            logic [7:0] pat;
            int len;
            we  = ($urandom_range(0, 39) == 0);
            pat = 8'($urandom);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
            ovl = 1'($urandom);
            v   = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom);
            clr = ($urandom_range(0, 149) == 0);
            apply(we, pat, len, ovl, v, b, clr);
            check("rand_match", int'(match), m_match);
            check("rand_count", int'(match_count), m_count);
            check("rand_count2", int'(match_count2), m_count2);
            check("rand_fill", int'(fill), model_fill());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
